// File: rtl/tm_lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron array.
// Holds the sequencer state encoding and the update pipeline depth.
package tm_lif_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } lif_state_e;

   localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/lif_update_pipe.sv
// Three-stage LIF membrane update: leak/recovery multiply, synaptic sum with
// saturation and refractory handling, then threshold/spike and write-back.
module lif_update_pipe #(
   parameter int N_NEURON = 16,
   parameter int VW       = 10,
   parameter int RW       = 9,
   parameter int REFW     = 4,
   parameter int IW       = $clog2(N_NEURON)
) (
   input  logic                   clk_in,
   input  logic                   reset_n,
   input  logic                   issue,
   input  logic [IW-1:0]          issue_idx,
   input  logic signed [VW-1:0]   vmem_rd,
   input  logic [REFW-1:0]        refr_rd,
   input  logic signed [VW-1:0]   syn_i,
   input  logic [RW-1:0]          leak_rate,
   input  logic [RW-1:0]          charge_rate,
   input  logic signed [VW-1:0]   Vth,
   input  logic signed [VW-1:0]   Vrst,
   input  logic [REFW-1:0]        ref_period,
   output logic                   wb_valid,
   output logic [IW-1:0]          wb_idx,
   output logic signed [VW-1:0]   wb_vmem,
   output logic [REFW-1:0]        wb_refr,
   output logic                   spike,
   output logic                   sweep_done
);

   localparam int PW = VW + RW + 1;
   localparam logic [IW-1:0]        LAST_IDX = IW'(N_NEURON - 1);
   localparam logic signed [VW-1:0] V_MAX    = {1'b0, {(VW-1){1'b1}}};
   localparam logic signed [VW-1:0] V_MIN    = {1'b1, {(VW-1){1'b0}}};

   logic                 s1_valid;
   logic [IW-1:0]        s1_idx;
   logic signed [VW-1:0] s1_vmem;
   logic [REFW-1:0]      s1_refr;
   logic signed [VW-1:0] s1_syn;

   logic                 s2_valid;
   logic [IW-1:0]        s2_idx;
   logic signed [VW-1:0] s2_sum;
   logic                 s2_refr_zero;
   logic [REFW-1:0]      s2_refr_dec;

   logic [RW-1:0]        s1_rate;
   logic signed [PW-1:0] s1_a_ext;
   logic signed [PW-1:0] s1_b_ext;
   logic signed [PW-1:0] s1_prod;
   logic signed [VW-1:0] s1_vdec;
   logic signed [VW:0]   s1_wide;
   logic signed [VW-1:0] s1_sum_nx;
   logic [REFW-1:0]      s1_refr_nx;
   logic                 s2_fire;
   logic                 unused_prod_bits;

   // Product is scaled by 2^RW; keep bits [RW +: VW], i.e. an arithmetic
   // shift right by RW. Since rate < 2^RW the result always fits in VW bits.
   always_comb begin
      s1_rate    = s1_vmem[VW-1] ? charge_rate : leak_rate;
      s1_a_ext   = PW'(s1_vmem);
      s1_b_ext   = PW'($signed({1'b0, s1_rate}));
      s1_prod    = s1_a_ext * s1_b_ext;
      s1_vdec    = s1_prod[RW +: VW];
      s1_wide    = (VW+1)'(s1_vdec) + (VW+1)'(s1_syn);
      s1_sum_nx  = s1_vdec;
      s1_refr_nx = '0;
      if (s1_refr != '0) begin
         s1_refr_nx = s1_refr - REFW'(1);
      end else if (s1_wide[VW] != s1_wide[VW-1]) begin
         s1_sum_nx = s1_wide[VW] ? V_MIN : V_MAX;
      end else begin
         s1_sum_nx = s1_wide[VW-1:0];
      end
   end

   assign unused_prod_bits = ^{s1_prod[RW-1:0], s1_prod[PW-1]};
   assign s2_fire = s2_refr_zero && (s2_sum > Vth);

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         s1_valid     <= 1'b0;
         s1_idx       <= '0;
         s1_vmem      <= '0;
         s1_refr      <= '0;
         s1_syn       <= '0;
         s2_valid     <= 1'b0;
         s2_idx       <= '0;
         s2_sum       <= '0;
         s2_refr_zero <= 1'b0;
         s2_refr_dec  <= '0;
         wb_valid     <= 1'b0;
         wb_idx       <= '0;
         wb_vmem      <= '0;
         wb_refr      <= '0;
         spike        <= 1'b0;
         sweep_done   <= 1'b0;
      end else begin
         s1_valid <= issue;
         if (issue) begin
            s1_idx  <= issue_idx;
            s1_vmem <= vmem_rd;
            s1_refr <= refr_rd;
            s1_syn  <= syn_i;
         end

         s2_valid     <= s1_valid;
         s2_idx       <= s1_idx;
         s2_sum       <= s1_sum_nx;
         s2_refr_zero <= (s1_refr == '0);
         s2_refr_dec  <= s1_refr_nx;

         wb_valid   <= s2_valid;
         wb_idx     <= s2_idx;
         wb_vmem    <= (s2_valid && s2_fire) ? Vrst : s2_sum;
         wb_refr    <= (s2_valid && s2_fire) ? ref_period : s2_refr_dec;
         spike      <= s2_valid && s2_fire;
         sweep_done <= s2_valid && (s2_idx == LAST_IDX);
      end
   end

endmodule

// File: rtl/tm_lif_array.sv
// Time-multiplexed LIF neuron array: sweep sequencer, neuron index counter
// and per-neuron membrane/refractory state, feeding lif_update_pipe.
//
//   state | meaning
//   IDLE  | no issue; index held for the next run
//   RUN   | one neuron issued per cycle, index wraps at N_NEURON-1
//   DRAIN | no issue; PIPE_DEPTH cycles to flush in-flight write-backs
module tm_lif_array
   import tm_lif_pkg::*;
#(
   parameter int N_NEURON = 16,
   parameter int VW       = 10,
   parameter int RW       = 9,
   parameter int REFW     = 4
) (
   input  logic                          clk_in,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [RW-1:0]                 leak_rate,
   input  logic [RW-1:0]                 charge_rate,
   input  logic signed [VW-1:0]          Vth,
   input  logic signed [VW-1:0]          Vrst,
   input  logic [REFW-1:0]               ref_period,
   input  logic signed [VW-1:0]          syn_i,
   output logic [$clog2(N_NEURON)-1:0]   idx_o,
   output logic                          issue_o,
   output logic                          spike_o,
   output logic [$clog2(N_NEURON)-1:0]   spike_idx_o,
   output logic signed [VW-1:0]          vmem_o,
   output logic                          wb_valid_o,
   output logic                          sweep_done_o,
   output logic                          busy_o
);

   localparam int IW = $clog2(N_NEURON);
   localparam logic [IW-1:0] LAST_IDX   = IW'(N_NEURON - 1);
   localparam logic [1:0]    DRAIN_LOAD = 2'(PIPE_DEPTH - 1);

   lif_state_e state, state_nx;
   logic [1:0]           drain_cnt;
   logic [IW-1:0]        idx;
   logic signed [VW-1:0] vmem [N_NEURON];
   logic [REFW-1:0]      refr [N_NEURON];

   logic                 wb_valid;
   logic [IW-1:0]        wb_idx;
   logic signed [VW-1:0] wb_vmem;
   logic [REFW-1:0]      wb_refr;
   logic                 spike;
   logic                 sweep_done;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (enable) state_nx = RUN;
         RUN:     if (!enable) state_nx = DRAIN;
         DRAIN:   if (drain_cnt == 2'd0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign issue_o = (state == RUN);
   assign busy_o  = (state != IDLE);
   assign idx_o   = idx;

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state     <= IDLE;
         drain_cnt <= 2'd0;
         idx       <= '0;
      end else begin
         state <= state_nx;
         if (state == RUN && state_nx == DRAIN) begin
            drain_cnt <= DRAIN_LOAD;
         end else if (state == DRAIN && drain_cnt != 2'd0) begin
            drain_cnt <= drain_cnt - 2'd1;
         end
         if (issue_o) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
         end
      end
   end

   // Reads need no bypass: with N_NEURON >= 4 a neuron is written back
   // before it comes up for issue again.
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         for (int i = 0; i < N_NEURON; i++) begin
            vmem[i] <= '0;
            refr[i] <= '0;
         end
      end else if (wb_valid) begin
         vmem[wb_idx] <= wb_vmem;
         refr[wb_idx] <= wb_refr;
      end
   end

   lif_update_pipe #(
      .N_NEURON (N_NEURON),
      .VW       (VW),
      .RW       (RW),
      .REFW     (REFW),
      .IW       (IW)
   ) u_pipe (
      .clk_in      (clk_in),
      .reset_n     (reset_n),
      .issue       (issue_o),
      .issue_idx   (idx),
      .vmem_rd     (vmem[idx]),
      .refr_rd     (refr[idx]),
      .syn_i       (syn_i),
      .leak_rate   (leak_rate),
      .charge_rate (charge_rate),
      .Vth         (Vth),
      .Vrst        (Vrst),
      .ref_period  (ref_period),
      .wb_valid    (wb_valid),
      .wb_idx      (wb_idx),
      .wb_vmem     (wb_vmem),
      .wb_refr     (wb_refr),
      .spike       (spike),
      .sweep_done  (sweep_done)
   );

   assign wb_valid_o   = wb_valid;
   assign spike_idx_o  = wb_idx;
   assign vmem_o       = wb_vmem;
   assign spike_o      = spike;
   assign sweep_done_o = sweep_done;

endmodule

// File: doc/tm_lif_array.md
TM_LIF_ARRAY -- requirements
Module: tm_lif_array

Interface
REQ-001 SHALL have parameter N_NEURON, default 16, number of time-multiplexed neurons (min 4, power of 2 not required).
REQ-002 SHALL have parameter VW, default 10, signed membrane/synapse/threshold width.
REQ-003 SHALL have parameter RW, default 9, unsigned rate width (rate/2^RW multiplier).
REQ-004 SHALL have parameter REFW, default 4, refractory counter width.
REQ-005 SHALL have ports: clk_in in 1 (clock); reset_n in 1 (synchronous, active-low reset).
REQ-006 SHALL have ports: enable in 1 (run sweeps); leak_rate in RW (decay when vmem>=0); charge_rate in RW (recovery when vmem<0).
REQ-007 SHALL have ports: Vth in VW signed; Vrst in VW signed; ref_period in REFW (post-spike refractory sweeps).
REQ-008 SHALL have ports: syn_i in VW signed (current for neuron named by idx_o, sampled same cycle); idx_o out clog2(N_NEURON) (neuron issued this cycle); issue_o out 1 (idx_o valid).
REQ-009 SHALL have ports: spike_o out 1; spike_idx_o out clog2(N_NEURON); vmem_o out VW (written-back value); wb_valid_o out 1; sweep_done_o out 1; busy_o out 1.

Function
REQ-010 SHALL hold per-neuron state in register arrays: vmem[N_NEURON] signed VW, refr[N_NEURON] REFW.
REQ-011 SHALL implement FSM IDLE -> RUN when enable=1; RUN -> DRAIN when enable=0; DRAIN -> IDLE after 3 cycles; DRAIN -> RUN if enable returns before drain completes is forbidden (drain always completes).
REQ-012 In RUN, SHALL issue one neuron per cycle (issue_o=1), index incrementing 0..N_NEURON-1 and wrapping to 0; index held (not reset) across IDLE.
REQ-013 Stage 1 SHALL register vmem, refr, syn_i and compute v_dec = (vmem * rate) arithmetic-shift-right RW, rate = leak_rate if vmem>=0 else charge_rate.
REQ-014 Stage 2: if refr>0, sum = v_dec, syn ignored, refr decremented; else sum = v_dec + syn, saturated to [-2^(VW-1), 2^(VW-1)-1].
REQ-015 Stage 3: if refr was 0 and sum > Vth (signed, strict): spike_o=1, vmem written Vrst, refr written ref_period; else vmem written sum.
REQ-016 Write-back and spike SHALL occur 3 cycles after issue; wb_valid_o=1, spike_idx_o and vmem_o reflect that neuron in the same cycle.
REQ-017 N_NEURON>=4 guarantees no read of a neuron before its previous write-back; no bypass logic.
REQ-018 sweep_done_o SHALL pulse 1 cycle with write-back of neuron N_NEURON-1.
REQ-019 busy_o=1 in RUN and DRAIN; parameter inputs SHALL be sampled at stage use, changes apply to subsequent neurons.

Reset
REQ-020 On reset_n=0 at clk_in edge: FSM IDLE, index 0, all vmem and refr 0, pipeline valids 0, all outputs 0.
REQ-021 Reset mid-sweep SHALL discard in-flight neurons with no write-back.

Structure
REQ-022 Shared package tm_lif_pkg SHALL hold FSM state typedef (IDLE, RUN, DRAIN) and pipeline depth constant (3).
REQ-023 Datapath stages 1-3 SHALL be sub-module lif_update_pipe; FSM, index counter and state arrays in top.

Verification (N_NEURON=4, VW=10, RW=9)
REQ-024 Reset: reset_n=0 one cycle -> all vmem 0, spike_o=0, busy_o=0, idx_o=0.
REQ-025 syn_i=100, leak_rate=511, Vth=250, Vrst=0, ref_period=0 -> neuron 0 vmem 100, 199, then spike on sweep 3, vmem 0.
REQ-026 As 025 with ref_period=2 -> after spike, next 2 sweeps vmem stays 0 despite syn_i=100; accumulation resumes sweep 3 after.
REQ-027 Preload vmem=500, leak_rate=511, syn_i=511, Vth=511 -> sum saturates 511, no spike, vmem_o=511.
REQ-028 Negative: vmem=-200, charge_rate=256, neuron refractory -> vmem_o=-100.
REQ-029 enable dropped after issuing idx 1 -> write-backs for idx 0,1 complete, IDLE, re-enable issues idx 2 first.
